// File: rtl/pipe_result_collector.sv
// pipe_result_collector: captures adder-chain results into a show-ahead FIFO drained by valid/ready.
// Captures arriving while full are dropped, flagged sticky and counted with saturation.
module pipe_result_collector #(
   parameter int SIZE  = 4,
   parameter int DEPTH = 4,
   parameter int CNT_W = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       in_load,
   input  logic [SIZE-1:0]            in_sum,
   input  logic                       in_carry,
   input  logic [SIZE-1:0]            in_op_a,
   input  logic [SIZE-1:0]            in_op_b,
   input  logic                       in_carry_in,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [SIZE:0]              out_result,
   output logic [SIZE-1:0]            out_op_a,
   output logic [SIZE-1:0]            out_op_b,
   output logic                       out_mismatch,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       overflow,
   output logic [CNT_W-1:0]           drop_cnt
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int EW = 3 * SIZE + 2;

   logic [EW-1:0]    mem_q [DEPTH];
   logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
   logic [CW-1:0]    count_q, count_d;
   logic             overflow_q, overflow_d;
   logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
   logic             pop, push, drop, full;
   logic [SIZE:0]    exp_sum;
   logic [EW-1:0]    head;

   always_comb begin
      pop        = (count_q != '0) & out_ready;
      full       = count_q == CW'(DEPTH);
      push       = in_load & (~full | pop);
      drop       = in_load & ~push;
      exp_sum    = (SIZE+1)'(in_op_a) + (SIZE+1)'(in_op_b) + (SIZE+1)'(in_carry_in);
      wr_d       = wr_q + AW'(push);
      rd_d       = rd_q + AW'(pop);
      count_d    = count_q + CW'(push) - CW'(pop);
      overflow_d = overflow_q | drop;
      drop_cnt_d = drop_cnt_q + CNT_W'(drop & ~&drop_cnt_q);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_q       <= '0;
         rd_q       <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         drop_cnt_q <= '0;
      end else begin
         wr_q       <= wr_d;
         rd_q       <= rd_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   // Data RAM is never cleared; validity is tracked by count alone.
   always_ff @(posedge clk) begin
      if (push && !reset)
         mem_q[wr_q] <= {in_carry, in_sum, in_op_a, in_op_b, {in_carry, in_sum} != exp_sum};
   end

   assign head         = mem_q[rd_q];
   assign out_valid    = count_q != '0;
   assign out_result   = head[EW-1 -: SIZE+1];
   assign out_op_a     = head[2*SIZE -: SIZE];
   assign out_op_b     = head[SIZE -: SIZE];
   assign out_mismatch = head[0];
   assign count        = count_q;
   assign overflow     = overflow_q;
   assign drop_cnt     = drop_cnt_q;
endmodule

// File: tb/tb_pipe_result_collector.sv
// tb_pipe_result_collector: randomized and directed stimulus checked against a queue-based model.
module tb_pipe_result_collector;
   logic       clk = 1'b0;
   logic       reset = 1'b1, in_load = 1'b0, in_carry = 1'b0, in_carry_in = 1'b0, out_ready = 1'b0;
   logic [3:0] in_sum = '0, in_op_a = '0, in_op_b = '0;
   logic       out_valid, out_mismatch, overflow;
   logic [4:0] out_result;
   logic [3:0] out_op_a, out_op_b;
   logic [2:0] count;
   logic [7:0] drop_cnt;
   logic       v2, mis2, ovf2;
   logic [4:0] res2;
   logic [3:0] a2, b2;
   logic [2:0] cnt2;
   logic [1:0] drop2;

   int checks = 0, errors = 0;
   bit chk_en = 0;
   logic [13:0] mq[$];
   bit m_ovf = 0;
   int m_drops = 0;

   pipe_result_collector #(.SIZE(4), .DEPTH(4), .CNT_W(8)) dut (
      .clk(clk), .reset(reset), .in_load(in_load), .in_sum(in_sum), .in_carry(in_carry),
      .in_op_a(in_op_a), .in_op_b(in_op_b), .in_carry_in(in_carry_in), .out_valid(out_valid),
      .out_ready(out_ready), .out_result(out_result), .out_op_a(out_op_a), .out_op_b(out_op_b),
      .out_mismatch(out_mismatch), .count(count), .overflow(overflow), .drop_cnt(drop_cnt));

   pipe_result_collector #(.SIZE(4), .DEPTH(4), .CNT_W(2)) dut2 (
      .clk(clk), .reset(reset), .in_load(in_load), .in_sum(in_sum), .in_carry(in_carry),
      .in_op_a(in_op_a), .in_op_b(in_op_b), .in_carry_in(in_carry_in), .out_valid(v2),
      .out_ready(out_ready), .out_result(res2), .out_op_a(a2), .out_op_b(b2),
      .out_mismatch(mis2), .count(cnt2), .overflow(ovf2), .drop_cnt(drop2));

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_step();
      logic [13:0] tmp;
      bit pop, push;
      int sz;
      if (reset) begin
         mq.delete();
         m_ovf = 0;
         m_drops = 0;
      end else begin
         sz = mq.size();
         pop = sz != 0 && out_ready;
         push = in_load && (sz < 4 || pop);
         if (pop) tmp = mq.pop_front();
         if (push)
            mq.push_back({in_carry, in_sum, in_op_a, in_op_b,
               1'(int'({in_carry, in_sum}) != int'(in_op_a) + int'(in_op_b) + int'(in_carry_in))});
         if (in_load && !push) begin
            m_ovf = 1;
            m_drops++;
         end
      end
   endtask

   task automatic cyc(input logic r, input logic ld, input logic rdy, input logic [3:0] s,
                      input logic c, input logic [3:0] a, input logic [3:0] b, input logic ci);
      reset = r; in_load = ld; out_ready = rdy;
      in_sum = s; in_carry = c; in_op_a = a; in_op_b = b; in_carry_in = ci;
      @(posedge clk);
      model_step();
      #1;
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("valid", int'(out_valid), int'(mq.size() != 0));
         chk("count", int'(count), mq.size());
         chk("overflow", int'(overflow), int'(m_ovf));
         chk("drop_cnt", int'(drop_cnt), m_drops > 255 ? 255 : m_drops);
         chk("drop_cnt_w2", int'(drop2), m_drops > 3 ? 3 : m_drops);
         if (mq.size() != 0)
            chk("head", int'({out_result, out_op_a, out_op_b, out_mismatch}), int'(mq[0]));
      end
   end

   initial begin
      cyc(1, 0, 0, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0, 0, 0);
      chk_en = 1;
      for (int i = 0; i < 3; i++) cyc(0, 1, 0, 4'(i), 0, 4'(i), 0, 0);
      cyc(1, 1, 1, 0, 0, 0, 0, 0);
      chk("rst_count", int'(count), 0);
      cyc(0, 1, 0, 4'd3, 0, 4'd1, 4'd2, 0);
      chk("t1_valid", int'(out_valid), 1);
      chk("t1_result", int'(out_result), 5'h03);
      chk("t1_mismatch", int'(out_mismatch), 0);
      cyc(0, 1, 1, 4'hF, 1, 4'd8, 4'd8, 0);
      chk("t2_result", int'(out_result), 5'h1F);
      chk("t2_mismatch", int'(out_mismatch), 1);
      cyc(1, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 1; i <= 6; i++) cyc(0, 1, 0, 4'(i), 0, 4'(i), 0, 0);
      chk("t3_count", int'(count), 4);
      chk("t3_overflow", int'(overflow), 1);
      chk("t3_drop", int'(drop_cnt), 2);
      chk("t3_head", int'(out_result), 1);
      cyc(0, 1, 1, 4'd9, 0, 4'd9, 0, 0);
      chk("t4_count", int'(count), 4);
      chk("t4_drop", int'(drop_cnt), 2);
      chk("t4_head", int'(out_result), 2);
      for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0, 0, 0, 0, 0);
      chk("t3_empty", int'(out_valid), 0);
      for (int i = 0; i < 12; i++) begin
         cyc(0, 1, 1, 4'(i), 0, 4'(i), 0, 0);
         chk("t5_count", int'(count), 1);
      end
      cyc(0, 0, 1, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 9; i++) cyc(0, 1, 0, 4'(i), 0, 4'(i), 4'(i), 1);
      chk("t6_drop_w2", int'(drop2), 3);
      chk("t6_drop_w8", int'(drop_cnt), 5);
      cyc(1, 1, 1, 0, 0, 0, 0, 0);
      chk("t6_valid", int'(out_valid), 0);
      chk("t6_count", int'(count), 0);
      chk("t6_overflow", int'(overflow), 0);
      chk("t6_drop", int'(drop_cnt), 0);
      for (int i = 0; i < 400; i++)
         cyc($urandom_range(0, 59) == 0, $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 4,
             4'($urandom), 1'($urandom), 4'($urandom), 4'($urandom), 1'($urandom));
      @(negedge clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
